// File: rtl/sr_seq_ctrl.sv
// sr_seq_ctrl: two-requester round-robin sequencer that streams a latched word MSB-first into a serial-in shift register.
// Optional feature macro SR_CHECK_EN: compares the captured sr word with the sent word and raises a sticky err.
module sr_seq_ctrl #(
    parameter int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             sr_in,
    input  logic [WIDTH-1:0] sr_out,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             err
);
    localparam int IDX_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CAPT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             sr_in_q, sr_in_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             pick;
    logic [WIDTH-1:0] word;
    logic [IDX_W-1:0] bitIdx;
`ifdef SR_CHECK_EN
    logic             err_q, err_d;
`endif

    // cnt counts bits already driven; the MSB goes out on the grant edge itself.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        id_d        = id_q;
        shadow_d    = shadow_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        sr_in_d     = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        pick        = req1 & ~(req0 & last_q);
        word        = pick ? data1 : data0;
        bitIdx      = IDX_W'(WIDTH - 1) - cnt_q[IDX_W-1:0];
`ifdef SR_CHECK_EN
        err_d       = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    id_d     = pick;
                    last_d   = pick;
                    shadow_d = word;
                    sr_in_d  = word[WIDTH-1];
                    cnt_d    = CNT_W'(1);
                    gnt0_d   = ~pick;
                    gnt1_d   = pick;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == CNT_W'(WIDTH)) begin
                    cnt_d   = '0;
                    state_d = CAPT;
                end else begin
                    sr_in_d = shadow_q[bitIdx];
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            CAPT: begin
                rsp_valid_d = 1'b1;
                rsp_id_d    = id_q;
                rsp_data_d  = sr_out;
                state_d     = IDLE;
`ifdef SR_CHECK_EN
                if (sr_out != shadow_q) begin
                    err_d = 1'b1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_q      <= 1'b1;
            id_q        <= 1'b0;
            shadow_q    <= '0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            sr_in_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            id_q        <= id_d;
            shadow_q    <= shadow_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            sr_in_q     <= sr_in_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

`ifdef SR_CHECK_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign busy      = (state_q != IDLE);
    assign sr_in     = sr_in_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_sr_seq_ctrl.sv
// tb_sr_seq_ctrl: bench for sr_seq_ctrl with an attached 4-bit serial-in shift register model.
// Directed vector table and corner sequences, then random traffic against a cycle-timeline model.
module tb_sr_seq_ctrl;
    localparam int W = 4;
    localparam int NRAND = 600;
`ifdef SR_CHECK_EN
    localparam logic CHECK_EN = 1'b1;
`else
    localparam logic CHECK_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         req0, req1;
    logic [W-1:0] data0, data1;
    logic         gnt0, gnt1, busy, sr_in;
    logic [W-1:0] srOut;
    logic         rsp_valid, rsp_id;
    logic [W-1:0] rsp_data;
    logic         err;

    logic [W-1:0] srReg = '0;
    logic         stuckBit0 = 1'b0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic         r0;
        logic [W-1:0] d0;
        logic         r1;
        logic [W-1:0] d1;
        logic         expId;
        logic [W-1:0] expData;
    } vec_t;
    vec_t vecs[7];

    int           gCyc[$];
    logic         gId[$];
    logic         rIdQ[$];
    logic [W-1:0] rDataQ[$];

    sr_seq_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .data0(data0), .req1(req1), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .sr_in(sr_in), .sr_out(srOut),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) srReg <= {srReg[W-2:0], sr_in};
    assign srOut = stuckBit0 ? (srReg & {{(W-1){1'b1}}, 1'b0}) : srReg;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkIdle(input string name);
        checkOutput(name, 32'({gnt0, gnt1, busy, sr_in, rsp_valid, rsp_id, rsp_data, err}), 32'd0);
    endtask

    // One full transaction from IDLE: grant, W serial bits, capture cycle, response pulse.
    task automatic applyStimulus(input logic r0, input logic [W-1:0] d0, input logic r1,
                                 input logic [W-1:0] d1, input logic expId,
                                 input logic [W-1:0] expData, input logic [W-1:0] expRsp,
                                 input string tag);
        int waitCnt;
        req0 = r0; data0 = d0; req1 = r1; data1 = d1;
        waitCnt = 0;
        do begin
            tick();
            waitCnt++;
        end while (!(gnt0 || gnt1) && waitCnt < 20);
        checkOutput({tag, ".gnt"}, 32'({gnt1, gnt0}), expId ? 32'd2 : 32'd1);
        req0 = 1'b0; req1 = 1'b0; data0 = ~d0; data1 = ~d1;
        for (int k = 0; k < W; k++) begin
            checkOutput({tag, ".srin"}, 32'(sr_in), 32'(expData[W-1-k]));
            checkOutput({tag, ".busy"}, 32'(busy), 32'd1);
            if (k == 1) checkOutput({tag, ".gntlow"}, 32'({gnt1, gnt0}), 32'd0);
            tick();
        end
        checkOutput({tag, ".capt"}, 32'({busy, sr_in, rsp_valid}), 32'b100);
        tick();
        checkOutput({tag, ".rsp"}, 32'({busy, rsp_valid, rsp_id, rsp_data}),
                    32'({1'b0, 1'b1, expId, expRsp}));
        tick();
        checkOutput({tag, ".rspend"}, 32'(rsp_valid), 32'd0);
    endtask

    // Hold requests for holdCyc cycles, swapping data after each grant, and log events.
    task automatic observeHeld(input logic r0, input logic [W-1:0] d0, input logic [W-1:0] nd0,
                               input logic r1, input logic [W-1:0] d1, input int holdCyc,
                               input string tag);
        gCyc.delete(); gId.delete(); rIdQ.delete(); rDataQ.delete();
        req0 = r0; data0 = d0; req1 = r1; data1 = d1;
        for (int c = 0; c < holdCyc + W + 3; c++) begin
            tick();
            checkOutput({tag, ".excl"}, 32'((gnt0 && gnt1) || (rsp_valid && (gnt0 || gnt1))), 32'd0);
            if (gnt0) begin gCyc.push_back(c); gId.push_back(1'b0); data0 = nd0; end
            if (gnt1) begin gCyc.push_back(c); gId.push_back(1'b1); end
            if (rsp_valid) begin rIdQ.push_back(rsp_id); rDataQ.push_back(rsp_data); end
            if (c == holdCyc - 1) begin req0 = 1'b0; req1 = 1'b0; end
        end
    endtask

    // Random traffic checked against a timeline of expected outputs per edge.
    task automatic runRandom();
        logic         sG0 [0:NRAND+W+3];
        logic         sG1 [0:NRAND+W+3];
        logic         sSr [0:NRAND+W+3];
        logic         sBusy [0:NRAND+W+3];
        logic         sRv [0:NRAND+W+3];
        logic         sRid [0:NRAND+W+3];
        logic [W-1:0] sRd [0:NRAND+W+3];
        int           freeAt;
        logic         mLast, mErr, id;
        logic [W-1:0] w;
        for (int i = 0; i <= NRAND + W + 3; i++) begin
            sG0[i] = 0; sG1[i] = 0; sSr[i] = 0; sBusy[i] = 0; sRv[i] = 0; sRid[i] = 0; sRd[i] = '0;
        end
        freeAt = 0; mLast = 1'b1; mErr = 1'b0;
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
        for (int t = 0; t < NRAND; t++) begin
            if (!rst) begin
                for (int k = t; k < t + W + 3; k++) begin
                    sG0[k] = 0; sG1[k] = 0; sSr[k] = 0; sBusy[k] = 0; sRv[k] = 0;
                end
                freeAt = t + 1; mLast = 1'b1; mErr = 1'b0;
            end else if (t >= freeAt && (req0 || req1)) begin
                id = (req0 && req1) ? !mLast : req1;
                w = id ? data1 : data0;
                sG0[t] = !id; sG1[t] = id;
                for (int k = 0; k < W; k++) sSr[t+k] = w[W-1-k];
                for (int k = 0; k <= W; k++) sBusy[t+k] = 1'b1;
                sRv[t+W+1] = 1'b1; sRid[t+W+1] = id; sRd[t+W+1] = w;
                freeAt = t + W + 2; mLast = id;
            end
            tick();
            checkOutput("rnd.ctl", 32'({gnt0, gnt1, sr_in, busy, rsp_valid, err}),
                        32'({sG0[t], sG1[t], sSr[t], sBusy[t], sRv[t], mErr}));
            if (sRv[t]) checkOutput("rnd.rsp", 32'({rsp_id, rsp_data}), 32'({sRid[t], sRd[t]}));
            rst = ($urandom_range(0, 79) != 0);
            if (gnt0) req0 = 1'b0;
            else if (!req0 && $urandom_range(0, 2) == 0) begin req0 = 1'b1; data0 = W'($urandom); end
            if (gnt1) req1 = 1'b0;
            else if (!req1 && $urandom_range(0, 2) == 0) begin req1 = 1'b1; data1 = W'($urandom); end
        end
    endtask

    initial begin
        vecs[0] = '{1'b1, 4'h3, 1'b1, 4'hC, 1'b0, 4'h3};
        vecs[1] = '{1'b1, 4'hB, 1'b0, 4'h5, 1'b0, 4'hB};
        vecs[2] = '{1'b0, 4'h2, 1'b1, 4'h9, 1'b1, 4'h9};
        vecs[3] = '{1'b1, 4'h5, 1'b1, 4'hA, 1'b0, 4'h5};
        vecs[4] = '{1'b1, 4'h7, 1'b1, 4'h8, 1'b1, 4'h8};
        vecs[5] = '{1'b1, 4'h6, 1'b0, 4'h1, 1'b0, 4'h6};
        vecs[6] = '{1'b1, 4'h2, 1'b1, 4'hD, 1'b1, 4'hD};

        rst = 1'b0; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
        tick();
        checkIdle("reset");
        tick();
        rst = 1'b1;
        tick();

        // Reset in the middle of a word: the word is dropped and never answered.
        req0 = 1'b1; data0 = 4'hA;
        tick();
        checkOutput("drop.gnt", 32'(gnt0), 32'd1);
        req0 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        checkIdle("drop.rst1");
        tick();
        checkIdle("drop.rst2");
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checkOutput("drop.quiet", 32'({rsp_valid, busy}), 32'd0);
        end

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].r0, vecs[i].d0, vecs[i].r1, vecs[i].d1,
                          vecs[i].expId, vecs[i].expData, vecs[i].expData, $sformatf("vec%0d", i));
        end

        // Both held: strict alternation every W+2 cycles.
        observeHeld(1'b1, 4'h3, 4'h3, 1'b1, 4'hC, 13, "alt");
        checkOutput("alt.ngnt", 32'(gId.size()), 32'd3);
        checkOutput("alt.nrsp", 32'(rIdQ.size()), 32'd3);
        if (gId.size() >= 3 && rIdQ.size() >= 3) begin
            checkOutput("alt.ids", 32'({gId[0], gId[1], gId[2]}), 32'b010);
            checkOutput("alt.gap1", 32'(gCyc[1] - gCyc[0]), 32'd6);
            checkOutput("alt.gap2", 32'(gCyc[2] - gCyc[1]), 32'd6);
            checkOutput("alt.rids", 32'({rIdQ[0], rIdQ[1], rIdQ[2]}), 32'b010);
            checkOutput("alt.rdata", 32'({rDataQ[0], rDataQ[1], rDataQ[2]}), 32'h3C3);
        end

        // Back-to-back words from one requester.
        observeHeld(1'b1, 4'hF, 4'h0, 1'b0, 4'h5, 7, "b2b");
        checkOutput("b2b.ngnt", 32'(gCyc.size()), 32'd2);
        checkOutput("b2b.nrsp", 32'(rDataQ.size()), 32'd2);
        if (gCyc.size() >= 2 && rDataQ.size() >= 2) begin
            checkOutput("b2b.gap", 32'(gCyc[1] - gCyc[0]), 32'd6);
            checkOutput("b2b.rdata", 32'({rDataQ[0], rDataQ[1]}), 32'hF0);
        end

        checkOutput("err.clean", 32'(err), 32'd0);
        // Stuck sr bit: rsp shows the corrupted word; err only with the checker built in.
        stuckBit0 = 1'b1;
        applyStimulus(1'b1, 4'h1, 1'b0, 4'h0, 1'b0, 4'h1, 4'h0, "stuck");
        stuckBit0 = 1'b0;
        checkOutput("stuck.err", 32'(err), 32'(CHECK_EN));
        tick(); tick(); tick();
        checkOutput("stuck.sticky", 32'(err), 32'(CHECK_EN));
        applyStimulus(1'b0, 4'h0, 1'b1, 4'h6, 1'b1, 4'h6, 4'h6, "stuck.after");
        checkOutput("stuck.sticky2", 32'(err), 32'(CHECK_EN));
        rst = 1'b0;
        tick();
        checkOutput("stuck.clr", 32'(err), 32'd0);
        rst = 1'b1;
        tick();

        runRandom();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
